// File: rtl/uart_tx_keepalive.sv
// 8N1 UART transmitter with idle keepalive injection: after KEEPALIVE_SECONDS of
// idle-high line a KEEPALIVE_BYTE frame is sent so the peer's idle timeout restarts.
module uart_tx_keepalive #(
   parameter int unsigned SYS_CLK_RATE      = 50_000_000,
   parameter int unsigned BAUD_RATE         = 9600,
   parameter int unsigned KEEPALIVE_SECONDS = 30,
   parameter logic [7:0]  KEEPALIVE_BYTE    = 8'h16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       keepalive_en,
   output logic       serial_out,
   output logic       busy,
   output logic       keepalive_sent
);

   localparam int unsigned CLKS_PER_BIT = SYS_CLK_RATE / BAUD_RATE;
   localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PRE_W        = (SYS_CLK_RATE > 1) ? $clog2(SYS_CLK_RATE) : 1;
   localparam int unsigned SEC_W        = 6;
   localparam int unsigned BIT_W        = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [SEC_W-1:0]   sec_q, sec_d;
   logic               serial_q, serial_d;
   logic               tx_ready_q, tx_ready_d;
   logic               busy_q, busy_d;
   logic               ka_sent_q, ka_sent_d;

   logic               accept_c;
   logic               ka_due_c;
   logic               ka_launch_c;
   logic               baud_last_c;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      pre_d       = '0;
      sec_d       = '0;
      accept_c    = tx_valid && tx_ready_q;
      ka_due_c    = (state_q == IDLE) && keepalive_en &&
                    (sec_q == SEC_W'(KEEPALIVE_SECONDS));
      // A user byte on the due cycle takes precedence; any frame restarts the peer timer.
      ka_launch_c = ka_due_c && !accept_c;
      baud_last_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (accept_c) begin
               state_d = START;
               shift_d = tx_data;
            end else if (ka_launch_c) begin
               state_d = START;
               shift_d = KEEPALIVE_BYTE;
            end else if (pre_q == PRE_W'(SYS_CLK_RATE - 1)) begin
               pre_d = '0;
               sec_d = (sec_q == SEC_W'(KEEPALIVE_SECONDS)) ? sec_q : sec_q + SEC_W'(1);
            end else begin
               pre_d = pre_q + PRE_W'(1);
               sec_d = sec_q;
            end
         end
         START: begin
            if (baud_last_c) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last_c) begin
               baud_d = '0;
               if (bit_q == BIT_W'(7)) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_last_c) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      serial_d   = (state_d == DATA) ? shift_d[0] : (state_d != START);
      tx_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
      ka_sent_d  = ka_launch_c;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         pre_q      <= '0;
         sec_q      <= '0;
         serial_q   <= 1'b1;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         ka_sent_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         pre_q      <= pre_d;
         sec_q      <= sec_d;
         serial_q   <= serial_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         ka_sent_q  <= ka_sent_d;
      end
   end

   assign serial_out     = serial_q;
   assign tx_ready       = tx_ready_q;
   assign busy           = busy_q;
   assign keepalive_sent = ka_sent_q;

endmodule

// File: tb/tb_uart_tx_keepalive.sv
// Directed bench for uart_tx_keepalive at 100 Hz clock, 10 baud, 3 s keepalive.
module tb_uart_tx_keepalive;

   localparam int unsigned CPB   = 10;
   localparam int unsigned FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       keepalive_en = 1'b0;
   logic       serial_out;
   logic       busy;
   logic       keepalive_sent;

   int errors = 0;
   int checks = 0;

   uart_tx_keepalive #(
      .SYS_CLK_RATE      (100),
      .BAUD_RATE         (10),
      .KEEPALIVE_SECONDS (3),
      .KEEPALIVE_BYTE    (8'h16)
   ) dut (
      .sys_clk        (clk),
      .sys_rst_n      (rst_n),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .keepalive_en   (keepalive_en),
      .serial_out     (serial_out),
      .busy           (busy),
      .keepalive_sent (keepalive_sent)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves reset released just after an edge; the next edge is the first live one.
   task automatic do_reset();
      rst_n = 1'b0;
      tx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Samples a whole frame starting at the launch sample; returns decoded byte and flags.
   task automatic grab_frame(output logic [7:0] data, output logic frame_ok,
                             output logic hold_ok, output int ka_cnt);
      data = '0;
      frame_ok = 1'b1;
      hold_ok = 1'b1;
      ka_cnt = 0;
      for (int k = 0; k < int'(FRAME); k++) begin
         int b;
         if (k > 0) step();
         b = k / int'(CPB);
         if (keepalive_sent === 1'b1) ka_cnt++;
         if (busy !== 1'b1 || tx_ready !== 1'b0) hold_ok = 1'b0;
         if (b == 0) begin
            if (serial_out !== 1'b0) frame_ok = 1'b0;
         end else if (b == 9) begin
            if (serial_out !== 1'b1) frame_ok = 1'b0;
         end else if (k % int'(CPB) == 0) begin
            data[b-1] = serial_out;
         end else if (serial_out !== data[b-1]) begin
            frame_ok = 1'b0;
         end
      end
   endtask

   task automatic count_to_ks(input int limit, output int n, output logic found);
      n = 0;
      found = 1'b0;
      while (n < limit && !found) begin
         step();
         n++;
         if (keepalive_sent === 1'b1) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      keepalive_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (serial_out !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b0 || keepalive_sent !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ser=%b rdy=%b busy=%b ka=%b expected 1 0 0 0",
                  serial_out, tx_ready, busy, keepalive_sent);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 0", tx_ready);
      end
      step();
      checks++;
      if (tx_ready !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_edge: got rdy=%b busy=%b ser=%b expected 1 0 1",
                  tx_ready, busy, serial_out);
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] d;
      logic fok, hok;
      int kc;
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      tx_data = 8'h00;
      checks++;
      if (serial_out !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL a5_launch: got ser=%b busy=%b rdy=%b expected 0 1 0", serial_out, busy, tx_ready);
      end
      grab_frame(d, fok, hok, kc);
      checks++;
      if (d !== 8'hA5 || fok !== 1'b1) begin
         errors++;
         $display("FAIL a5_frame: got data=%h framing=%b expected a5 1", d, fok);
      end
      checks++;
      if (hok !== 1'b1 || kc != 0) begin
         errors++;
         $display("FAIL a5_busy: got hold=%b ka=%0d expected 1 0", hok, kc);
      end
      step();
      checks++;
      if (tx_ready !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b1) begin
         errors++;
         $display("FAIL a5_return_idle: got rdy=%b busy=%b ser=%b expected 1 0 1", tx_ready, busy, serial_out);
      end
   endtask

   task automatic test_keepalive_idle();
      logic [7:0] d;
      logic fok, hok, found;
      int kc, n;
      keepalive_en = 1'b1;
      do_reset();
      step();
      count_to_ks(1000, n, found);
      checks++;
      if (!found || n != 300) begin
         errors++;
         $display("FAIL ka_first_time: got found=%b steps=%0d expected 1 300", found, n);
      end
      grab_frame(d, fok, hok, kc);
      checks++;
      if (d !== 8'h16 || fok !== 1'b1 || hok !== 1'b1 || kc != 1) begin
         errors++;
         $display("FAIL ka_frame: got data=%h framing=%b hold=%b ka=%0d expected 16 1 1 1", d, fok, hok, kc);
      end
      step();
      count_to_ks(1000, n, found);
      checks++;
      if (!found || n != 301) begin
         errors++;
         $display("FAIL ka_repeat_time: got found=%b steps=%0d expected 1 301", found, n);
      end
      grab_frame(d, fok, hok, kc);
      checks++;
      if (d !== 8'h16 || fok !== 1'b1) begin
         errors++;
         $display("FAIL ka_repeat_frame: got data=%h framing=%b expected 16 1", d, fok);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      logic [7:0] d;
      logic fok, hok;
      int kc;
      vals[0] = 8'h00;
      vals[1] = 8'hFF;
      vals[2] = 8'h55;
      keepalive_en = 1'b1;
      do_reset();
      step();
      tx_data = vals[0];
      tx_valid = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (serial_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_launch_%0d: got ser=%b busy=%b expected 0 1", i, serial_out, busy);
         end
         if (i < 2) tx_data = vals[i+1];
         else tx_valid = 1'b0;
         grab_frame(d, fok, hok, kc);
         checks++;
         if (d !== vals[i] || fok !== 1'b1 || hok !== 1'b1 || kc != 0) begin
            errors++;
            $display("FAIL b2b_frame_%0d: got data=%h framing=%b hold=%b ka=%0d expected %h 1 1 0",
                     i, d, fok, hok, kc, vals[i]);
         end
         step();
         checks++;
         if (tx_ready !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap_%0d: got rdy=%b busy=%b ser=%b expected 1 0 1", i, tx_ready, busy, serial_out);
         end
         step();
      end
   endtask

   task automatic test_collision();
      logic [7:0] d;
      logic fok, hok, found;
      int kc, n;
      keepalive_en = 1'b1;
      do_reset();
      step();
      repeat (299) step();
      tx_data = 8'h3C;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      checks++;
      if (serial_out !== 1'b0 || keepalive_sent !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL collide_launch: got ser=%b ka=%b busy=%b expected 0 0 1", serial_out, keepalive_sent, busy);
      end
      grab_frame(d, fok, hok, kc);
      checks++;
      if (d !== 8'h3C || fok !== 1'b1 || kc != 0) begin
         errors++;
         $display("FAIL collide_frame: got data=%h framing=%b ka=%0d expected 3c 1 0", d, fok, kc);
      end
      step();
      count_to_ks(1000, n, found);
      checks++;
      if (!found || n != 301) begin
         errors++;
         $display("FAIL collide_next_ka: got found=%b steps=%0d expected 1 301", found, n);
      end
      repeat (FRAME) step();
   endtask

   task automatic test_enable_gate();
      logic quiet;
      keepalive_en = 1'b0;
      do_reset();
      step();
      quiet = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (serial_out !== 1'b1 || busy !== 1'b0 || keepalive_sent !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         errors++;
         $display("FAIL gate_quiet: got quiet=%b expected 1", quiet);
      end
      keepalive_en = 1'b1;
      step();
      checks++;
      if (keepalive_sent !== 1'b1 || serial_out !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gate_reenable: got ka=%b ser=%b busy=%b expected 1 0 1", keepalive_sent, serial_out, busy);
      end
      step();
      checks++;
      if (keepalive_sent !== 1'b0) begin
         errors++;
         $display("FAIL gate_pulse_width: got %b expected 0", keepalive_sent);
      end
      repeat (FRAME) step();
   endtask

   task automatic test_reset_midframe();
      logic found;
      int n;
      keepalive_en = 1'b1;
      do_reset();
      step();
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      repeat (55) step();
      checks++;
      if (serial_out !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_bit4: got ser=%b busy=%b expected 0 1", serial_out, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (serial_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_async_reset: got ser=%b busy=%b rdy=%b expected 1 0 0", serial_out, busy, tx_ready);
      end
      do_reset();
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_release_ready: got %b expected 0", tx_ready);
      end
      step();
      checks++;
      if (tx_ready !== 1'b1 || serial_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_first_edge: got rdy=%b ser=%b expected 1 1", tx_ready, serial_out);
      end
      count_to_ks(1000, n, found);
      checks++;
      if (!found || n != 300) begin
         errors++;
         $display("FAIL mid_timer_restart: got found=%b steps=%0d expected 1 300", found, n);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_keepalive_idle();
      test_back_to_back();
      test_collision();
      test_enable_gate();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_keepalive.md
Name: uart_tx_keepalive

Overview:
8N1 UART transmitter for the link whose receiver declares timeout after 60 s of idle-high line. Serializes bytes from an upstream valid/ready source. When the line has been idle for KEEPALIVE_SECONDS, it injects a keepalive byte so the far-end receiver's timeout counter restarts. Sits between the system byte producer and the serial output pin.

Parameters:
SYS_CLK_RATE, 50_000_000, sys_clk frequency in Hz; also the prescaler length for the 1 s tick.
BAUD_RATE, 9600, line rate; CLKS_PER_BIT = SYS_CLK_RATE / BAUD_RATE, integer division (5208 at defaults).
KEEPALIVE_SECONDS, 30, whole idle seconds before a keepalive; must be less than the peer timeout (60); range 1..63.
KEEPALIVE_BYTE, 8'h16, byte sent as keepalive (SYN).

Ports:
sys_clk  in  1  system clock; all logic on posedge.
sys_rst_n  in  1  asynchronous, active-low reset.
tx_data  in  8  byte to send; sampled on the accept cycle.
tx_valid  in  1  upstream has a byte.
tx_ready  out  1  block accepts tx_data this cycle if tx_valid.
keepalive_en  in  1  1 = keepalive injection enabled.
serial_out  out  1  UART line; idle high.
busy  out  1  frame in progress.
keepalive_sent  out  1  one-cycle pulse on the cycle a keepalive frame is launched.

Behaviour:
- Reset (async assert): state IDLE; serial_out=1, tx_ready=0, busy=0, keepalive_sent=0; all counters 0. All outputs are registered. tx_ready rises on the first sys_clk edge after sys_rst_n deasserts.
- FSM states:
  - IDLE -> START on accept (tx_valid && tx_ready) or on keepalive launch.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Launch latency: accept or launch in cycle N -> serial_out=0 from cycle N+1.
  - In that same edge: tx_ready=0 and busy=1; shift register loads tx_data (or KEEPALIVE_BYTE for a keepalive).
- Frame length: exactly 10*CLKS_PER_BIT cycles of start+data+stop.
- Return to IDLE: tx_ready=1 and busy=0 on the cycle after the stop bit ends, giving one extra idle-high cycle between back-to-back frames. tx_data changes while busy are ignored.
- Baud counter: 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary. Bit counter: 0..7.
- Idle timer:
  - Prescaler counts 0..SYS_CLK_RATE-1 only in IDLE; it emits a 1 s tick on wrap.
  - The 6-bit idle_seconds counter increments on each tick and saturates at KEEPALIVE_SECONDS.
  - Outside IDLE, both prescaler and idle_seconds are held at 0. The timer therefore measures idle time since the end of the last stop bit, or since reset release.
- Keepalive due: IDLE && keepalive_en && idle_seconds==KEEPALIVE_SECONDS. On that cycle the frame launches (keepalive_sent=1, one cycle) and tx_ready is driven 0.
  - Net effect: the first keepalive starts exactly KEEPALIVE_SECONDS*SYS_CLK_RATE idle cycles after the line went idle.
- Simultaneous user byte and keepalive due: the user byte wins. It is accepted, there is no keepalive_sent pulse, and the timer clears (any frame satisfies the peer).
- keepalive_en=0: the timer still counts and saturates but no launch occurs. Re-enabling with the counter saturated launches on the next IDLE cycle.
- keepalive_en changing mid-frame has no effect on the current frame.
- Reset mid-frame: serial_out returns to 1 immediately (async); the partial frame is abandoned, with no completion.
- Continuous traffic: no keepalive is ever inserted while frames arrive with gaps shorter than KEEPALIVE_SECONDS.

Test Plan:
Bench parameters: SYS_CLK_RATE=100, BAUD_RATE=10 (CLKS_PER_BIT=10), KEEPALIVE_SECONDS=3, KEEPALIVE_BYTE=8'h16.
1. Reset, then send tx_data=8'hA5 with one-cycle tx_valid -> serial_out low next cycle for 10 clks, then bits 1,0,1,0,0,1,0,1 (10 clks each), stop high 10 clks; busy high 100 cycles; tx_ready back the cycle after.
2. Idle after reset with keepalive_en=1 -> keepalive_sent pulses at idle cycle 300; line carries 0x16 framed 8N1; repeats every 300+100+1 cycles while idle.
3. tx_valid=1 continuously with 0x00,0xFF,0x55 -> three frames, one idle cycle between each, no keepalive_sent.
4. tx_valid asserted on the exact cycle the keepalive is due -> user byte is sent, keepalive_sent stays 0, next keepalive 300 idle cycles after its stop bit.
5. keepalive_en=0 for 1000 idle cycles -> no frame; raise keepalive_en -> keepalive launches the next cycle.
6. Assert sys_rst_n=0 during data bit 4 -> serial_out=1 immediately, busy=0, tx_ready=0; after release, tx_ready=1 next edge and the idle timer restarts from 0.
